// File: rtl/fir_ctrl_pkg.sv
// rtl/fir_ctrl_pkg.sv - shared defaults and state encoding for the FIR sequencing controller
package fir_ctrl_pkg;

    localparam int TAPS_DEFAULT = 8;
    localparam int AW_DEFAULT   = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } fir_state_e;

endpackage

// File: rtl/fir_tap_cnt.sv
// rtl/fir_tap_cnt.sv - tap address counter with clear, increment and terminal-count flag
module fir_tap_cnt #(
    parameter int TAPS = 8,
    parameter int AW   = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [AW-1:0] cnt_o,
    output logic          tc_o
);

    logic [AW-1:0] cnt_q;
    logic [AW-1:0] cnt_d;
    logic          tc;

    assign tc = (cnt_q == AW'(TAPS - 1));

    // Increment saturates at the terminal count so the address never wraps within a pass.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !tc) begin
            cnt_d = cnt_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = tc;

endmodule

// File: rtl/fir_ctrl.sv
// rtl/fir_ctrl.sv - FIR filter sequencing controller: accept sample, walk taps, drain, hand off result
module fir_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int TAPS = TAPS_DEFAULT,
    parameter int AW   = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          shift_en,
    output logic          ld_ir,
    output logic [AW-1:0] tap_addr,
    output logic          clr_acc,
    output logic          mac_en,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy
);

    fir_state_e    state_q;
    logic          mac_en_q;
    logic          accept;
    logic          in_mac;
    logic          last_tap;
    logic [AW-1:0] tap_cnt;

    assign in_ready  = (state_q == ST_IDLE);
    assign accept    = in_ready && in_valid;
    assign in_mac    = (state_q == ST_MAC);
    assign shift_en  = accept;
    assign clr_acc   = accept;
    assign ld_ir     = in_mac;
    assign tap_addr  = in_mac ? tap_cnt : '0;
    assign out_valid = (state_q == ST_OUT);
    assign busy      = !in_ready;
    assign mac_en    = mac_en_q;

    // Counter is cleared on acceptance and again after the last tap so it rests at zero.
    fir_tap_cnt #(
        .TAPS (TAPS),
        .AW   (AW)
    ) u_tap_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (accept || (in_mac && last_tap)),
        .inc_i (in_mac),
        .cnt_o (tap_cnt),
        .tc_o  (last_tap)
    );

    // mac_en trails ld_ir by one cycle: operands appear only after the address register loads.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mac_en_q <= 1'b0;
        end else begin
            mac_en_q <= in_mac;
            case (state_q)
                ST_IDLE:  if (in_valid) state_q <= ST_MAC;
                ST_MAC:   if (last_tap) state_q <= ST_DRAIN;
                ST_DRAIN: state_q <= ST_OUT;
                ST_OUT:   if (out_ready) state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_ctrl.sv
// tb/tb_fir_ctrl.sv - self-checking bench for fir_ctrl at TAPS=8 and TAPS=2
module tb_fir_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;

    logic       in_ready_w  [2];
    logic       shift_w     [2];
    logic       ld_ir_w     [2];
    logic [7:0] addr_w      [2];
    logic       clr_w       [2];
    logic       mac_w       [2];
    logic       ov_w        [2];
    logic       busy_w      [2];

    int errors = 0;
    int checks = 0;
    int pos [2] = '{0, 0};
    int tp  [2] = '{8, 2};
    logic ov_s [2];
    logic sh_s [2];

    always #5 clk = ~clk;

    fir_ctrl #(.TAPS(8), .AW(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]),
        .shift_en(shift_w[0]), .ld_ir(ld_ir_w[0]), .tap_addr(addr_w[0]),
        .clr_acc(clr_w[0]), .mac_en(mac_w[0]), .out_valid(ov_w[0]),
        .out_ready(out_ready), .busy(busy_w[0])
    );

    fir_ctrl #(.TAPS(2), .AW(8)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]),
        .shift_en(shift_w[1]), .ld_ir(ld_ir_w[1]), .tap_addr(addr_w[1]),
        .clr_acc(clr_w[1]), .mac_en(mac_w[1]), .out_valid(ov_w[1]),
        .out_ready(out_ready), .busy(busy_w[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: pos counts cycles since acceptance (0 = idle, waiting for a sample).
    task automatic check_dut(input int k);
        int p;
        int t;
        string n;
        p = pos[k];
        t = tp[k];
        n = $sformatf("T%0d", t);
        chk({n, " in_ready"},  32'(in_ready_w[k]), 32'(p == 0));
        chk({n, " busy"},      32'(busy_w[k]),     32'(p != 0));
        chk({n, " shift_en"},  32'(shift_w[k]),    32'(p == 0 && in_valid));
        chk({n, " clr_acc"},   32'(clr_w[k]),      32'(p == 0 && in_valid));
        chk({n, " ld_ir"},     32'(ld_ir_w[k]),    32'(p >= 1 && p <= t));
        chk({n, " tap_addr"},  32'(addr_w[k]),     (p >= 1 && p <= t) ? 32'(p - 1) : 32'd0);
        chk({n, " mac_en"},    32'(mac_w[k]),      32'(p >= 2 && p <= t + 1));
        chk({n, " out_valid"}, 32'(ov_w[k]),       32'(p >= t + 2));
    endtask

    task automatic advance_model(input int k);
        int t;
        t = tp[k];
        if (rst)                            pos[k] = 0;
        else if (pos[k] == 0 && in_valid)   pos[k] = 1;
        else if (pos[k] >= 1 && pos[k] <= t + 1) pos[k] = pos[k] + 1;
        else if (pos[k] >= t + 2 && out_ready)   pos[k] = 0;
    endtask

    task automatic step(input logic r, input logic iv, input logic ordy);
        rst = r;
        in_valid = iv;
        out_ready = ordy;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check_dut(k);
            ov_s[k] = ov_w[k];
            sh_s[k] = shift_w[k];
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) advance_model(k);
        #1;
    endtask

    initial begin
        int first_ov8;
        int first_ov2;
        int cnt;

        @(posedge clk);
        #1;
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0);

        first_ov8 = -1;
        first_ov2 = -1;
        for (int i = 0; i < 14; i++) begin
            step(1'b0, i == 0, 1'b1);
            if (ov_s[0] && first_ov8 < 0) first_ov8 = i;
            if (ov_s[1] && first_ov2 < 0) first_ov2 = i;
        end
        chk("latency T8", 32'(first_ov8), 32'd10);
        chk("latency T2", 32'(first_ov2), 32'd4);

        cnt = 0;
        step(1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 14; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (ov_s[0]) cnt++;
        end
        chk("backpressure hold T8", 32'(cnt), 32'd5);
        step(1'b0, 1'b0, 1'b1);
        chk("release out_valid T8", 32'(ov_s[0]), 32'd1);
        step(1'b0, 1'b0, 1'b1);
        repeat (2) step(1'b0, 1'b0, 1'b1);

        cnt = 0;
        for (int i = 0; i < 44; i++) begin
            step(1'b0, 1'b1, 1'b1);
            if (sh_s[0]) cnt++;
        end
        chk("streaming accepts T8", 32'(cnt), 32'd4);

        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, 1'b1);
            if (ov_s[0]) cnt++;
        end
        chk("abandoned pass T8", 32'(cnt), 32'd0);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 29) == 0, 1'($urandom), $urandom_range(0, 2) == 0);
        end
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
